// File: rtl/serial_add_defs.sv
// rtl/serial_add_defs.sv - shared state encoding and operand limits for the bit-serial adder
package serial_add_defs;

    // Controller states. Encoding 2'd3 is unused and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Supported operand widths.
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // Bit-counter width for a given operand width (at least one bit).
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/fa_bit.sv
// rtl/fa_bit.sv - combinational 1-bit full adder built from two half-adder stages
//
// Ports:
//   x, y  in   addend bits
//   ci    in   carry-in
//   s     out  sum bit
//   co    out  carry-out
module fa_bit (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_hs1_s;
    logic w_hs1_c;
    logic w_hs2_c;

    // First half adder: x + y
    assign w_hs1_s = x ^ y;
    assign w_hs1_c = x & y;

    // Second half adder: partial sum + carry-in
    assign s       = w_hs1_s ^ ci;
    assign w_hs2_c = w_hs1_s & ci;

    // At most one half adder can generate a carry, so OR merges them
    assign co      = w_hs1_c | w_hs2_c;

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller, one bit per clock, LSB first
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only in ST_IDLE / ST_DONE
//   a, b   in   WIDTH-bit operands, captured on the accepted start edge
//   cin    in   carry-in, captured on the accepted start edge
//   busy   out  high while the add is running
//   done   out  one-cycle pulse, sum/cout valid
//   sum    out  WIDTH-bit result, held until the next completion
//   cout   out  carry-out of the MSB, held with sum
module serial_add_ctrl
    import serial_add_defs::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int              CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           r_state;
    state_e           w_next_state;

    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum_sr;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_accept;
    logic             w_running;
    logic             w_last;
    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_sum_shift;

    // The single shared full-adder cell
    fa_bit u_fa_bit (
        .x  (r_a_sr[0]),
        .y  (r_b_sr[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_c)
    );

    // A request is only taken when not running; ST_DONE accepts back-to-back.
    assign w_accept    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_running   = (r_state == ST_RUN);
    assign w_last      = w_running && (r_cnt == CNT_LAST);
    // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at LSB.
    assign w_sum_shift = {w_s, r_sum_sr[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and status outputs
    always_comb begin
        w_next_state = ST_IDLE;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_next_state = start ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                busy         = 1'b1;
                w_next_state = (r_cnt == CNT_LAST) ? ST_DONE : ST_RUN;
            end
            ST_DONE: begin
                done         = 1'b1;
                w_next_state = start ? ST_RUN : ST_IDLE;
            end
            default: begin
                // Illegal encoding: fall back to idle, outputs stay inactive
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath: operand shifters, carry, bit counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else if (w_accept) begin
            r_a_sr   <= a;
            r_b_sr   <= b;
            r_sum_sr <= '0;
            r_carry  <= cin;
            r_cnt    <= '0;
        end else if (w_running) begin
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_sum_sr <= w_sum_shift;
            r_carry  <= w_c;
            if (w_last) begin
                // Counter is left at its final value rather than wrapping
                r_sum  <= w_sum_shift;
                r_cout <= w_c;
            end else begin
                r_cnt  <= r_cnt + CNT_ONE;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
